// File: rtl/encode_onehot_stream.sv
`default_nettype none
// ============================================================================
// Module   : encode_onehot_stream
// Purpose  : Registered one-hot-to-binary encoder with a valid/ready stream
//            interface. MODE 0 accepts only strict one-hot inputs; MODE 1
//            encodes the lowest set bit and flags multi-hot inputs. It keeps
//            a saturating count and a sticky flag of unencodable inputs.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   i_clk        in   1   rising-edge clock
//   i_rst_n      in   1   asynchronous active-low reset
//   i_val        in   N   one-hot (or multi-hot) input vector
//   i_valid      in   1   i_val valid this cycle
//   o_ready      out  1   block can accept i_val this cycle
//   o_val        out  W   encoded index, all-ones when o_unknown = 1
//   o_unknown    out  1   input could not be encoded
//   o_multi      out  1   more than one bit set (MODE 1 only)
//   o_valid      out  1   output register holds a result
//   i_ready      in   1   downstream accepts the output this cycle
//   i_err_clr    in   1   synchronous clear of error statistics
//   o_err_cnt    out  CW  saturating count of accepted unknown inputs
//   o_err_sticky out  1   set by first accepted unknown input
// ============================================================================
module encode_onehot_stream #(
    parameter  int N    = 10,
    parameter  int MODE = 0,
    parameter  int CW   = 8,
    localparam int W    = $clog2(N)
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic [N-1:0]  i_val,
    input  logic          i_valid,
    output logic          o_ready,
    output logic [W-1:0]  o_val,
    output logic          o_unknown,
    output logic          o_multi,
    output logic          o_valid,
    input  logic          i_ready,
    input  logic          i_err_clr,
    output logic [CW-1:0] o_err_cnt,
    output logic          o_err_sticky
);

    localparam logic [N-1:0] C_ONE = {{(N-1){1'b0}}, 1'b1};

    typedef enum logic [0:0] {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [W-1:0]    val_q, val_d;
    logic            unknown_q, unknown_d;
    logic            multi_q, multi_d;
    logic [CW-1:0]   err_cnt_q, err_cnt_d;
    logic            err_sticky_q, err_sticky_d;

    logic [W-1:0]    low_idx;
    logic [N-1:0]    val_minus_one;
    logic            any_set;
    logic            multi_hot;
    logic [W-1:0]    enc_idx;
    logic            enc_unknown;
    logic            enc_multi;
    logic            accept;
    logic            load;

    // ------------------------------------------------------------------
    // Encoder: descending scan so the lowest set index is the last write.
    // x & (x-1) clears the lowest set bit; anything left means multi-hot.
    // ------------------------------------------------------------------
    always_comb begin
        low_idx = '1;
        for (int i = N - 1; i >= 0; i--) begin
            if (i_val[i]) begin
                low_idx = W'(i);
            end
        end
    end

    assign val_minus_one = i_val - C_ONE;
    assign any_set       = |i_val;
    assign multi_hot     = |(i_val & val_minus_one);

    generate
        if (MODE == 0) begin : g_mode_strict
            assign enc_unknown = !any_set || multi_hot;
            assign enc_idx     = enc_unknown ? {W{1'b1}} : low_idx;
            assign enc_multi   = 1'b0;
        end else begin : g_mode_priority
            // With no bit set the scan leaves low_idx at all-ones already.
            assign enc_unknown = !any_set;
            assign enc_idx     = low_idx;
            assign enc_multi   = multi_hot;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Output stage: single register with full flag. A full register can
    // be refilled in the cycle it is drained, giving full throughput.
    // ------------------------------------------------------------------
    assign o_ready = (state_q == ST_EMPTY) || i_ready;
    assign accept  = i_valid && o_ready;

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        case (state_q)
            ST_EMPTY: begin
                if (accept) begin
                    state_d = ST_FULL;
                    load    = 1'b1;
                end
            end
            ST_FULL: begin
                if (accept) begin
                    load = 1'b1;
                end else if (i_ready) begin
                    state_d = ST_EMPTY;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    always_comb begin
        val_d     = val_q;
        unknown_d = unknown_q;
        multi_d   = multi_q;
        if (load) begin
            val_d     = enc_idx;
            unknown_d = enc_unknown;
            multi_d   = enc_multi;
        end
    end

    // ------------------------------------------------------------------
    // Error statistics update at acceptance, independent of back-pressure.
    // A coincident clear takes priority over a new error.
    // ------------------------------------------------------------------
    always_comb begin
        err_cnt_d    = err_cnt_q;
        err_sticky_d = err_sticky_q;
        if (i_err_clr) begin
            err_cnt_d    = '0;
            err_sticky_d = 1'b0;
        end else if (accept && enc_unknown) begin
            err_sticky_d = 1'b1;
            if (!(&err_cnt_q)) begin
                err_cnt_d = err_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= ST_EMPTY;
            val_q        <= '1;
            unknown_q    <= 1'b0;
            multi_q      <= 1'b0;
            err_cnt_q    <= '0;
            err_sticky_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            val_q        <= val_d;
            unknown_q    <= unknown_d;
            multi_q      <= multi_d;
            err_cnt_q    <= err_cnt_d;
            err_sticky_q <= err_sticky_d;
        end
    end

    assign o_valid      = (state_q == ST_FULL);
    assign o_val        = val_q;
    assign o_unknown    = unknown_q;
    assign o_multi      = multi_q;
    assign o_err_cnt    = err_cnt_q;
    assign o_err_sticky = err_sticky_q;

endmodule
`default_nettype wire

// File: tb/tb_encode_onehot_stream.sv
`default_nettype none
// ============================================================================
// Module   : tb_encode_onehot_stream
// Purpose  : Directed self-checking bench. Three instances cover strict
//            mode (CW=8), priority mode, and a 2-bit saturating counter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_encode_onehot_stream;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    always #5 clk = ~clk;

    int tests_run    = 0;
    int tests_failed = 0;

    // Instance A: N=10, MODE=0, CW=8
    logic [9:0] a_val;
    logic       a_valid, a_ready, a_clr;
    logic       a_oready, a_ounk, a_omulti, a_ovalid, a_sticky;
    logic [3:0] a_oval;
    logic [7:0] a_cnt;

    // Instance B: N=10, MODE=1, CW=8
    logic [9:0] b_val;
    logic       b_valid, b_ready, b_clr;
    logic       b_oready, b_ounk, b_omulti, b_ovalid, b_sticky;
    logic [3:0] b_oval;
    logic [7:0] b_cnt;

    // Instance C: N=10, MODE=0, CW=2
    logic [9:0] c_val;
    logic       c_valid, c_ready, c_clr;
    logic       c_oready, c_ounk, c_omulti, c_ovalid, c_sticky;
    logic [3:0] c_oval;
    logic [1:0] c_cnt;

    encode_onehot_stream #(.N(10), .MODE(0), .CW(8)) u_dut_a (
        .i_clk(clk), .i_rst_n(rst_n), .i_val(a_val), .i_valid(a_valid),
        .o_ready(a_oready), .o_val(a_oval), .o_unknown(a_ounk),
        .o_multi(a_omulti), .o_valid(a_ovalid), .i_ready(a_ready),
        .i_err_clr(a_clr), .o_err_cnt(a_cnt), .o_err_sticky(a_sticky)
    );

    encode_onehot_stream #(.N(10), .MODE(1), .CW(8)) u_dut_b (
        .i_clk(clk), .i_rst_n(rst_n), .i_val(b_val), .i_valid(b_valid),
        .o_ready(b_oready), .o_val(b_oval), .o_unknown(b_ounk),
        .o_multi(b_omulti), .o_valid(b_ovalid), .i_ready(b_ready),
        .i_err_clr(b_clr), .o_err_cnt(b_cnt), .o_err_sticky(b_sticky)
    );

    encode_onehot_stream #(.N(10), .MODE(0), .CW(2)) u_dut_c (
        .i_clk(clk), .i_rst_n(rst_n), .i_val(c_val), .i_valid(c_valid),
        .o_ready(c_oready), .o_val(c_oval), .o_unknown(c_ounk),
        .o_multi(c_omulti), .o_valid(c_ovalid), .i_ready(c_ready),
        .i_err_clr(c_clr), .o_err_cnt(c_cnt), .o_err_sticky(c_sticky)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle just after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        a_val = '0; a_valid = 1'b0; a_ready = 1'b1; a_clr = 1'b0;
        b_val = '0; b_valid = 1'b0; b_ready = 1'b1; b_clr = 1'b0;
        c_val = '0; c_valid = 1'b0; c_ready = 1'b1; c_clr = 1'b0;

        // ---------------- reset ----------------
        #1 rst_n = 1'b0;
        step();
        step();
        check("rst_valid",   32'(a_ovalid), 0);
        check("rst_val",     32'(a_oval),   15);
        check("rst_unknown", 32'(a_ounk),   0);
        check("rst_multi",   32'(a_omulti), 0);
        check("rst_cnt",     32'(a_cnt),    0);
        check("rst_sticky",  32'(a_sticky), 0);
        check("rst_ready",   32'(a_oready), 1);
        rst_n = 1'b1;
        step();
        check("post_rst_ready", 32'(a_oready), 1);

        // ---------------- one-hot stream, MODE 0 ----------------
        for (int k = 0; k < 10; k++) begin
            a_val   = 10'(1) << k;
            a_valid = 1'b1;
            step();
            check($sformatf("oh_val%0d", k),   32'(a_oval),   32'(k));
            check($sformatf("oh_vld%0d", k),   32'(a_ovalid), 1);
            check($sformatf("oh_unk%0d", k),   32'(a_ounk),   0);
            check($sformatf("oh_cnt%0d", k),   32'(a_cnt),    0);
        end
        a_valid = 1'b0;
        step();
        check("oh_drain_valid", 32'(a_ovalid), 0);

        // ---------------- unknown inputs, MODE 0 ----------------
        a_val = 10'b0; a_valid = 1'b1;
        step();
        check("zero_val",    32'(a_oval),   15);
        check("zero_unk",    32'(a_ounk),   1);
        check("zero_cnt",    32'(a_cnt),    1);
        check("zero_sticky", 32'(a_sticky), 1);
        a_val = 10'b0000000011;
        step();
        check("two_val",     32'(a_oval),   15);
        check("two_unk",     32'(a_ounk),   1);
        check("two_multi",   32'(a_omulti), 0);
        check("two_cnt",     32'(a_cnt),    2);
        check("two_sticky",  32'(a_sticky), 1);
        a_valid = 1'b0;
        step();

        // ---------------- priority mode ----------------
        b_val = 10'b0101000100; b_valid = 1'b1;
        step();
        check("pri_val",   32'(b_oval),   2);
        check("pri_multi", 32'(b_omulti), 1);
        check("pri_unk",   32'(b_ounk),   0);
        b_val = 10'b1000000000;
        step();
        check("pri_single_val",   32'(b_oval),   9);
        check("pri_single_multi", 32'(b_omulti), 0);
        b_val = 10'b0;
        step();
        check("pri_zero_val",   32'(b_oval),   15);
        check("pri_zero_unk",   32'(b_ounk),   1);
        check("pri_zero_multi", 32'(b_omulti), 0);
        check("pri_zero_cnt",   32'(b_cnt),    1);
        b_valid = 1'b0;
        step();

        // ---------------- back-pressure ----------------
        a_ready = 1'b1; a_val = 10'b0000100000; a_valid = 1'b1;
        step();
        check("bp_load_val", 32'(a_oval),   5);
        check("bp_load_vld", 32'(a_ovalid), 1);
        a_ready = 1'b0; a_val = 10'b0000000010;
        #1;
        check("bp_ready_low", 32'(a_oready), 0);
        for (int k = 0; k < 3; k++) begin
            step();
            check($sformatf("bp_hold_val%0d", k), 32'(a_oval),   5);
            check($sformatf("bp_hold_rdy%0d", k), 32'(a_oready), 0);
            check($sformatf("bp_hold_vld%0d", k), 32'(a_ovalid), 1);
        end
        a_ready = 1'b1;
        #1;
        check("bp_ready_up", 32'(a_oready), 1);
        step();
        check("bp_next_val", 32'(a_oval),   1);
        check("bp_next_vld", 32'(a_ovalid), 1);
        a_valid = 1'b0;
        step();
        check("bp_no_dup", 32'(a_ovalid), 0);
        check("bp_cnt",    32'(a_cnt),    2);

        // ---------------- saturation and clear, CW=2 ----------------
        c_val = 10'b0; c_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            check($sformatf("sat_cnt%0d", k), 32'(c_cnt), (k < 3) ? 32'(k + 1) : 32'd3);
        end
        check("sat_sticky", 32'(c_sticky), 1);
        c_clr = 1'b1;
        step();
        check("clr_cnt",    32'(c_cnt),    0);
        check("clr_sticky", 32'(c_sticky), 0);
        c_clr = 1'b0; c_valid = 1'b0;
        step();
        check("clr_hold_cnt", 32'(c_cnt), 0);

        // ---------------- asynchronous reset mid-operation ----------------
        a_val = 10'b0010000000; a_valid = 1'b1; a_ready = 1'b1;
        step();
        check("ar_val_before", 32'(a_oval),   7);
        check("ar_vld_before", 32'(a_ovalid), 1);
        a_valid = 1'b0; a_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("ar_valid", 32'(a_ovalid), 0);
        check("ar_val",   32'(a_oval),   15);
        check("ar_cnt",   32'(a_cnt),    0);
        check("ar_ready", 32'(a_oready), 1);
        rst_n = 1'b1;
        step();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
`default_nettype wire
